// File: rtl/res_station_array_pkg.sv
// Shared Tomasulo types for the reservation-station array: dispatch word, ALU word,
// CDB payload and the per-entry storage record.
package tomasula_types;

    localparam int ROB_SIZE_DEF = 8;
    localparam int TAG_W        = $clog2(ROB_SIZE_DEF);
    localparam int RS_AGE_W     = 4;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SLT    = 4'd5,
        OP_LUI    = 4'd6,
        OP_AUIPC  = 4'd7,
        OP_JAL    = 4'd8,
        OP_JALR   = 4'd9,
        OP_BRANCH = 4'd10,
        OP_LOAD   = 4'd11,
        OP_STORE  = 4'd12
    } op_t;

    // Ops at or above this code take src1 from dispatch only (no CDB snoop).
    localparam logic [3:0] LOAD_OP_BOUND = 4'd11;

    typedef struct packed {
        op_t              op;
        logic [2:0]       funct3;
        logic [31:0]      pc;
        logic             src1_valid;
        logic [TAG_W-1:0] src1_tag;
        logic [31:0]      src1_data;
        logic             src2_valid;
        logic [TAG_W-1:0] src2_tag;
        logic [31:0]      src2_data;
        logic [TAG_W-1:0] rd_tag;
    } res_word;

    typedef struct packed {
        op_t              op;
        logic [2:0]       funct3;
        logic [31:0]      pc;
        logic [31:0]      src1;
        logic [31:0]      src2;
        logic [TAG_W-1:0] tag;
    } alu_word;

    typedef struct packed {
        logic [31:0] data;
    } cdb_data;

    typedef struct packed {
        logic                valid;
        logic [RS_AGE_W-1:0] age;
        res_word             word;
    } rs_entry_t;

    function automatic logic snoops_src1(input op_t op);
        return (op < LOAD_OP_BOUND);
    endfunction

    function automatic logic is_pc_op(input op_t op);
        return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH) ||
               (op == OP_AUIPC) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/res_station_array_if.sv
// Dispatch / snoop / issue bundle of the reservation-station array.
// master = dispatch+ALU environment, slave = the station array.
interface res_station_array_if
    import tomasula_types::*;
#(
    parameter int DEPTH    = 4,
    parameter int ROB_SIZE = ROB_SIZE_DEF
);
    logic                      load_word;
    res_word                   res_in;
    logic                      flush_ip;
    cdb_data [ROB_SIZE-1:0]    cdb;
    logic    [ROB_SIZE-1:0]    robs_calculated;
    logic    [ROB_SIZE-1:0]    allocated_rob_entries;
    logic                      exe_ready;
    alu_word                   alu_data;
    logic                      start_exe;
    logic                      jalr_executed;
    logic                      ld_pc_to_cdb;
    logic                      update_br;
    logic                      full;
    logic                      empty;
    logic [$clog2(DEPTH):0]    count;

    modport master (
        output load_word, res_in, flush_ip, cdb, robs_calculated,
               allocated_rob_entries, exe_ready,
        input  alu_data, start_exe, jalr_executed, ld_pc_to_cdb, update_br,
               full, empty, count
    );

    modport slave (
        input  load_word, res_in, flush_ip, cdb, robs_calculated,
               allocated_rob_entries, exe_ready,
        output alu_data, start_exe, jalr_executed, ld_pc_to_cdb, update_br,
               full, empty, count
    );
endinterface

// File: rtl/res_station_array_age_select.sv
// Combinational oldest-ready picker: largest age wins, ties go to the lowest index.
module rs_age_select #(
    parameter int DEPTH = 4,
    parameter int AGE_W = 4,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0]            ready,
    input  logic [DEPTH-1:0][AGE_W-1:0] ages,
    output logic [DEPTH-1:0]            grant,
    output logic [IDX_W-1:0]            idx,
    output logic                        found
);
    logic [AGE_W-1:0] best_s;
    logic [DEPTH-1:0] take_s;

    // Ascending scan with strict compare keeps the lowest index on equal ages
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        best_s = '0;
        take_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            take_s[i] = ready[i] & (~found | (ages[i] > best_s));
            found     = found | take_s[i];
            best_s    = take_s[i] ? ages[i] : best_s;
            idx       = take_s[i] ? IDX_W'(i) : idx;
        end
        grant = found ? (DEPTH'(1) << idx) : '0;
    end
endmodule

// File: rtl/res_station_array.sv
// DEPTH-entry reservation station feeding one ALU: snoops CDB results, issues the
// oldest ready entry, drops flushed entries. Define RS_BYPASS_EN for same-cycle CDB bypass.
module res_station_array
    import tomasula_types::*;
#(
    parameter int DEPTH    = 4,
    parameter int ROB_SIZE = ROB_SIZE_DEF,
    parameter int AGE_W    = RS_AGE_W
) (
    input logic                clk,
    input logic                rst,
    res_station_array_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    rs_entry_t                   ent_r [DEPTH];
    logic    [ROB_SIZE-1:0]      calc_s;
    logic    [ROB_SIZE-1:0]      live_s;
    cdb_data [ROB_SIZE-1:0]      cdb_s;
    logic [DEPTH-1:0]            valid_s;
    logic [DEPTH-1:0]            snoop1_s;
    logic [DEPTH-1:0]            snoop2_s;
    logic [DEPTH-1:0]            rdy1_s;
    logic [DEPTH-1:0]            rdy2_s;
    logic [DEPTH-1:0]            ready_s;
    logic [DEPTH-1:0]            kill_s;
    logic [DEPTH-1:0]            grant_s;
    logic [DEPTH-1:0][AGE_W-1:0] ages_s;
    logic [IDX_W-1:0]            sel_idx_s;
    logic [IDX_W-1:0]            free_idx_s;
    logic                        found_s;
    logic                        alloc_s;
    logic                        issue_s;
    logic                        full_s;
    logic [CNT_W-1:0]            cnt_s;
    res_word                     sel_w_s;
    alu_word                     alu_s;

    assign calc_s = bus.robs_calculated;
    assign live_s = bus.allocated_rob_entries;
    assign cdb_s  = bus.cdb;

    // Per-entry snoop hits, operand readiness and flush kills
    always_comb begin
        valid_s  = '0;
        ages_s   = '0;
        snoop1_s = '0;
        snoop2_s = '0;
        rdy1_s   = '0;
        rdy2_s   = '0;
        ready_s  = '0;
        kill_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_s[i]  = ent_r[i].valid;
            ages_s[i]   = ent_r[i].age;
            snoop1_s[i] = ~ent_r[i].word.src1_valid & calc_s[ent_r[i].word.src1_tag] &
                          snoops_src1(ent_r[i].word.op);
            snoop2_s[i] = ~ent_r[i].word.src2_valid & calc_s[ent_r[i].word.src2_tag];
`ifdef RS_BYPASS_EN
            rdy1_s[i]   = ent_r[i].word.src1_valid | snoop1_s[i];
            rdy2_s[i]   = ent_r[i].word.src2_valid | snoop2_s[i];
`else
            rdy1_s[i]   = ent_r[i].word.src1_valid;
            rdy2_s[i]   = ent_r[i].word.src2_valid;
`endif
            kill_s[i]   = ent_r[i].valid & ~live_s[ent_r[i].word.rd_tag];
            ready_s[i]  = ent_r[i].valid & live_s[ent_r[i].word.rd_tag] & rdy1_s[i] & rdy2_s[i];
        end
    end

    rs_age_select #(
        .DEPTH (DEPTH),
        .AGE_W (AGE_W),
        .IDX_W (IDX_W)
    ) u_age_select (
        .ready (ready_s),
        .ages  (ages_s),
        .grant (grant_s),
        .idx   (sel_idx_s),
        .found (found_s)
    );

    // Lowest free slot and occupancy count
    always_comb begin
        free_idx_s = '0;
        cnt_s      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free_idx_s = valid_s[i] ? free_idx_s : IDX_W'(i);
            cnt_s      = cnt_s + CNT_W'(valid_s[i]);
        end
    end

    assign full_s  = &valid_s;
    assign alloc_s = bus.load_word & ~full_s & ~bus.flush_ip;
    assign issue_s = found_s & bus.exe_ready;
    assign sel_w_s = ent_r[sel_idx_s].word;

    // Issued ALU word; zero whenever nothing issues
    always_comb begin
        alu_s = '0;
        if (issue_s) begin
            alu_s.op     = sel_w_s.op;
            alu_s.funct3 = ((sel_w_s.op == OP_JAL) || (sel_w_s.op == OP_JALR)) ? 3'b000
                                                                               : sel_w_s.funct3;
            alu_s.pc     = sel_w_s.pc;
            alu_s.tag    = sel_w_s.rd_tag;
`ifdef RS_BYPASS_EN
            alu_s.src1   = sel_w_s.src1_valid ? sel_w_s.src1_data : cdb_s[sel_w_s.src1_tag].data;
            alu_s.src2   = sel_w_s.src2_valid ? sel_w_s.src2_data : cdb_s[sel_w_s.src2_tag].data;
`else
            alu_s.src1   = sel_w_s.src1_data;
            alu_s.src2   = sel_w_s.src2_data;
`endif
        end else begin
            alu_s = '0;
        end
    end

    assign bus.alu_data      = alu_s;
    assign bus.start_exe     = issue_s;
    assign bus.jalr_executed = issue_s & (sel_w_s.op == OP_JALR);
    assign bus.ld_pc_to_cdb  = issue_s & is_pc_op(sel_w_s.op);
    assign bus.update_br     = issue_s & (sel_w_s.op == OP_BRANCH);
    assign bus.full          = full_s;
    assign bus.empty         = ~|valid_s;
    assign bus.count         = cnt_s;

    // Entry storage: issue/flush free, allocate fills, survivors age and snoop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((issue_s && grant_s[i]) || kill_s[i]) begin
                    ent_r[i].valid <= 1'b0;
                end else if (alloc_s && (free_idx_s == IDX_W'(i))) begin
                    ent_r[i].valid <= 1'b1;
                    ent_r[i].age   <= '0;
                    ent_r[i].word  <= bus.res_in;
                end else if (ent_r[i].valid) begin
                    if (alloc_s && (ent_r[i].age != AGE_MAX)) begin
                        ent_r[i].age <= ent_r[i].age + RS_AGE_W'(1);
                    end
                    if (snoop1_s[i]) begin
                        ent_r[i].word.src1_valid <= 1'b1;
                        ent_r[i].word.src1_data  <= cdb_s[ent_r[i].word.src1_tag].data;
                    end
                    if (snoop2_s[i]) begin
                        ent_r[i].word.src2_valid <= 1'b1;
                        ent_r[i].word.src2_data  <= cdb_s[ent_r[i].word.src2_tag].data;
                    end
                end
            end
        end
    end
endmodule
